// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG post-processing stage.
package trng_pkg;

    localparam int BYTE_W         = 8;
    localparam int RCT_CUTOFF_DEF = 32;
    localparam int RUN_W_DEF      = 6;

    localparam logic [BYTE_W-1:0] DROP_MAX = 8'd255;

    // FSM state encoding kept as plain constants for legacy tooling
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COLLECT = 2'd1;
    localparam state_t ST_FAIL    = 2'd2;

endpackage

// File: rtl/trng_postproc_if.sv
// Byte output handshake between the TRNG post-processor and its consumer.
interface trng_postproc_if;
    import trng_pkg::*;

    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/trng_vn_corrector.sv
// Von Neumann de-biasing corrector: non-overlapping pairs, 01 -> 0, 10 -> 1,
// 00/11 discarded. With bypass set, every valid bit passes straight through.
module trng_vn_corrector (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic in_bit,
    input  logic in_valid,
    input  logic bypass,
    output logic out_bit,
    output logic out_valid
);

    logic half_q, half_d;
    logic first_q, first_d;

    // Pair tracking and emission decision for the current input bit
    always_comb begin
        half_d    = half_q;
        first_d   = first_q;
        out_bit   = 1'b0;
        out_valid = 1'b0;
        if (clear) begin
            half_d  = 1'b0;
            first_d = 1'b0;
        end else if (in_valid) begin
            if (bypass) begin
                half_d    = 1'b0;
                out_bit   = in_bit;
                out_valid = 1'b1;
            end else if (!half_q) begin
                half_d  = 1'b1;
                first_d = in_bit;
            end else begin
                half_d = 1'b0;
                if (first_q != in_bit) begin
                    out_bit   = first_q;
                    out_valid = 1'b1;
                end else begin
                    out_valid = 1'b0;
                end
            end
        end else begin
            half_d = half_q;
        end
    end

    // Pair state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            half_q  <= half_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/trng_postproc.sv
// TRNG post-processor: repetition-count health test on raw bits, von Neumann
// correction, LSB-first byte packing and valid/ready output with drop count.
// Optional macro TRNG_VN_BYPASS_EN adds the vn_bypass input port.
module trng_postproc
    import trng_pkg::*;
#(
    parameter int RCT_CUTOFF = RCT_CUTOFF_DEF,
    parameter int RUN_W      = RUN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 raw_bit,
    input  logic                 raw_valid,
`ifdef TRNG_VN_BYPASS_EN
    input  logic                 vn_bypass,
`endif
    trng_postproc_if.master      out_if,
    output logic                 health_fail,
    output logic [BYTE_W-1:0]    drop_cnt
);

    state_t             state_q, state_d;
    logic               prev_q, prev_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]  pbyte_q, pbyte_d;
    logic [BYTE_W-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               health_fail_q, health_fail_d;
    logic [BYTE_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic active_s, take_s, clear_s, bypass_s, trip_s;
    logic vn_bit_s, vn_valid_s;

    // Raw bits count only while collecting with enable still high
    assign active_s = (state_q == ST_COLLECT) && enable;
    assign take_s   = active_s && raw_valid;
    assign clear_s  = !active_s;

`ifdef TRNG_VN_BYPASS_EN
    assign bypass_s = vn_bypass;
`else
    assign bypass_s = 1'b0;
`endif

    trng_vn_corrector u_vn (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_s),
        .in_bit    (raw_bit),
        .in_valid  (take_s),
        .bypass    (bypass_s),
        .out_bit   (vn_bit_s),
        .out_valid (vn_valid_s)
    );

    // Health test, packer, output handshake and FSM next-state logic
    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        run_d         = run_q;
        bit_idx_d     = bit_idx_q;
        pbyte_d       = pbyte_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        health_fail_d = health_fail_q;
        drop_cnt_d    = drop_cnt_q;

        // Repetition count; run==0 marks "no previous bit since entering COLLECT"
        if (!active_s) begin
            run_d  = {RUN_W{1'b0}};
            prev_d = 1'b0;
        end else if (raw_valid) begin
            prev_d = raw_bit;
            if ((run_q == {RUN_W{1'b0}}) || (raw_bit != prev_q)) begin
                run_d = {{(RUN_W-1){1'b0}}, 1'b1};
            end else if (run_q != {RUN_W{1'b1}}) begin
                run_d = run_q + {{(RUN_W-1){1'b0}}, 1'b1};
            end else begin
                run_d = run_q;
            end
        end else begin
            run_d = run_q;
        end
        trip_s = take_s && (run_d == RUN_W'(RCT_CUTOFF));

        // Consumer handshake; a same-cycle load below overrides the clear
        if (out_valid_q && out_if.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        // Packer: a completed byte loads only if the output slot frees up
        if (!active_s) begin
            bit_idx_d = 3'd0;
            pbyte_d   = {BYTE_W{1'b0}};
        end else if (vn_valid_s && !trip_s) begin
            pbyte_d[bit_idx_q] = vn_bit_s;
            bit_idx_d          = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
                if (!out_valid_q || out_if.out_ready) begin
                    out_data_d  = pbyte_d;
                    out_valid_d = 1'b1;
                end else if (drop_cnt_q != DROP_MAX) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end else begin
                    drop_cnt_d = drop_cnt_q;
                end
            end else begin
                out_data_d = out_data_q;
            end
        end else begin
            bit_idx_d = bit_idx_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (trip_s) begin
                    state_d       = ST_FAIL;
                    health_fail_d = 1'b1;
                    out_valid_d   = 1'b0;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_FAIL: begin
                state_d       = ST_FAIL;
                health_fail_d = 1'b1;
                out_valid_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            prev_q        <= 1'b0;
            run_q         <= {RUN_W{1'b0}};
            bit_idx_q     <= 3'd0;
            pbyte_q       <= {BYTE_W{1'b0}};
            out_data_q    <= {BYTE_W{1'b0}};
            out_valid_q   <= 1'b0;
            health_fail_q <= 1'b0;
            drop_cnt_q    <= {BYTE_W{1'b0}};
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            run_q         <= run_d;
            bit_idx_q     <= bit_idx_d;
            pbyte_q       <= pbyte_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            health_fail_q <= health_fail_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign health_fail      = health_fail_q;
    assign drop_cnt         = drop_cnt_q;

endmodule

// File: doc/trng_postproc.md
Name: trng_postproc

Overview:
- Post-processing stage downstream of the ring-oscillator entropy source.
- Consumes the raw sampled RO bit stream and removes bias with a von Neumann corrector.
- Runs a repetition-count health test (RCT) on the raw bits and packs corrected bits into bytes.
- Hands bytes to the consumer over a valid/ready interface; a failed health test latches off all output until reset.

Parameters:
- RCT_CUTOFF, 32, raw run length of identical bits that trips the health test; legal range 2..63.
- RUN_W, 6, width of the run counter; must satisfy 2^RUN_W > RCT_CUTOFF.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset; single clock domain
- enable  input  1  collection enable (drive from the RO activate control)
- raw_bit  input  1  raw entropy bit, already synchronised to clk
- raw_valid  input  1  raw_bit is a fresh sample this cycle
- out_data  output  8  packed random byte
- out_valid  output  1  out_data holds a byte
- out_ready  input  1  consumer accepts out_data this cycle
- health_fail  output  1  sticky RCT failure flag
- drop_cnt  output  8  saturating count of bytes dropped on back-pressure

Behaviour:
- Reset values (asynchronous): out_data=0, out_valid=0, health_fail=0, drop_cnt=0, FSM=IDLE; pair, bit-count and run registers cleared.
- FSM states:
  - IDLE: enable=0. Pair half-flag, bit count and run counter are held cleared. A pending out_data remains valid until it is handshaken.
  - COLLECT: enable=1 and no failure.
  - FAIL: terminal; left only by rst_n.
  - Transitions: IDLE->COLLECT when enable=1. COLLECT->IDLE when enable=0; partial byte and half pair are discarded. COLLECT->FAIL on RCT trip. enable has no effect in FAIL.
- Raw bits are processed only in COLLECT with raw_valid=1. raw_valid in IDLE or FAIL is ignored.
- Von Neumann corrector:
  - First bit of a pair is stored and half=1. Second bit clears half.
  - Pair 01 emits 0, pair 10 emits 1 (the emitted bit is the first bit). Pairs 00 and 11 emit nothing.
  - Pairs never overlap.
- Packer:
  - Emitted bits fill the byte LSB-first; bit index 0..7.
  - On the 8th emission the completed byte loads into out_data and out_valid=1 on the next edge (1-cycle latency from the completing raw_valid). The bit index wraps to 0.
  - The load is allowed if out_valid=0, or if out_valid=1 and out_ready=1 in the same cycle (simultaneous accept and load: the new byte replaces the old and out_valid stays 1).
  - If neither holds, the new byte is dropped and drop_cnt increments, saturating at 255.
- Output handshake:
  - out_valid && out_ready with no new load clears out_valid next edge.
  - out_data is stable while out_valid=1 and out_ready=0.
- Repetition-count test (on raw bits, before correction):
  - The first raw bit after entering COLLECT sets run=1.
  - Each following bit equal to the previous one increments run (saturating); a different bit resets run=1.
  - When run reaches RCT_CUTOFF: health_fail=1 next edge, FSM enters FAIL, out_valid is forced to 0, and any pending byte is discarded.
  - The corrector output of the tripping cycle is ignored.
- Reset mid-operation: asynchronous clear of everything, including health_fail and drop_cnt.

Optional Feature:
- Macro TRNG_VN_BYPASS_EN.
- Defined: adds input port vn_bypass (1 bit). When vn_bypass=1, every valid raw bit in COLLECT is emitted directly to the packer, 8 raw bits per byte, and the pair half-flag is held at 0. The RCT runs unchanged. vn_bypass is sampled per raw_valid.
- Undefined: no vn_bypass port; the corrector is always active.

Decomposition:
- Package trng_pkg holds:
  - the state typedef (IDLE, COLLECT, FAIL);
  - BYTE_W=8;
  - the DROP_MAX=255 constant;
  - default RCT_CUTOFF.
- One natural sub-module: trng_vn_corrector, which takes the raw bit/valid pair plus a clear input and emits bit/valid; the packer, RCT and FSM remain in the top.

Test Plan:
- Reset, enable=1, raw pairs 01,10,10,01,00,11,10,10,10,01 (pairs 1–4 and 7–10 productive), out_ready=1 -> out_valid 1 cycle after the last pair's second bit, out_data=8'b01110110 (LSB-first 0,1,1,0,1,1,1,0); 00/11 pairs produce nothing.
- Two full bytes with out_ready=0 -> first byte held stable, second dropped, drop_cnt=1. Then out_ready=1 -> out_valid drops next edge.
- Byte completes in the same cycle out_valid=1 and out_ready=1 -> new byte loaded, out_valid stays 1, drop_cnt unchanged.
- Raw bits:
  - 31 consecutive 1s -> health_fail=0.
  - 32nd 1 -> health_fail=1, FSM FAIL, out_valid=0.
  - Toggling enable afterwards does not clear it; only rst_n clears it.
- Partial byte (5 emitted bits), then enable=0 for 1 cycle, then enable=1 with 8 productive pairs -> out_data contains only the post-re-enable bits.
- With TRNG_VN_BYPASS_EN and vn_bypass=1, raw 1,0,1,1,0,0,1,0 -> out_data=8'h4D.
